seq_det_ctrl: RTL and testbench

//  Controller for the serial pattern detector: accepts a configuration (pattern,

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/pattern_match_core.sv | 54 +++++
 rtl/seq_det_ctrl.sv | 155 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: controller state encoding
// and the pattern-length clamp.
package seq_det_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Out-of-range lengths (zero or wider than the pattern field) select the full width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
    return ((len == 0) || (len > pat_w)) ? pat_w : len;
  endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial pattern matcher: history shift register, fill count and masked compare.
// hit flags a match for the bit being shifted in during the current cycle.
module pattern_match_core
  import seq_det_pkg::*;
#(
  parameter  int unsigned PAT_W = 4,
  localparam int unsigned LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;

  logic [PAT_W-1:0] w_hist_next;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] w_fill_inc;
  logic             w_cmp_eq;
  logic             w_hit;

  // Compare against the history including the incoming bit.
  always_comb begin
    w_hist_next = {r_hist[PAT_W-2:0], din};
    w_fill_inc  = (r_fill >= LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);
    w_mask      = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      w_mask[i] = (LEN_W'(i) < len);
    end
    w_cmp_eq = (((w_hist_next ^ pattern) & w_mask) == '0);
    w_hit    = shift && (w_fill_inc >= len) && w_cmp_eq;
  end

  assign hit = w_hit;

  // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_hist <= w_hist_next;
      r_fill <= (w_hit && !overlap) ? '0 : w_fill_inc;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Scan controller for the serial pattern detector: configuration capture,
// IDLE/RUN/DONE sequencing, scan-window and saturating match counters.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int unsigned PAT_W = 4,
  parameter  int unsigned CNT_W = 8,
  parameter  int unsigned WIN_W = 16,
  localparam int unsigned LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  state_e           w_state_next;

  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic [WIN_W-1:0] r_window;

  logic [WIN_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_count;
  logic             r_match;
  logic             r_done;
  logic             r_busy;
  logic             r_cfg_ready;

  logic             w_cfg_load;
  logic             w_start;
  logic [WIN_W-1:0] w_eff_window;
  logic             w_shift;
  logic             w_last_bit;
  logic [LEN_W-1:0] w_len_eff;
  logic             w_hit;

  always_comb begin
    w_cfg_load   = (r_state == IDLE) && cfg_valid;
    w_start      = (r_state == IDLE) && start;
    w_eff_window = cfg_valid ? cfg_window : r_window;
    w_shift      = (r_state == RUN) && din_valid && !abort;
    w_last_bit   = w_shift && (r_remaining == WIN_W'(1));
    w_len_eff    = LEN_W'(clamp_len(32'(r_len), PAT_W));
  end

  pattern_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_start),
    .shift   (w_shift),
    .din     (din),
    .pattern (r_pattern),
    .len     (w_len_eff),
    .overlap (r_overlap),
    .hit     (w_hit)
  );

  // Next-state logic; a zero-length window skips straight to DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (w_eff_window == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_last_bit) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register and status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cfg_ready <= (w_state_next == IDLE);
      r_busy      <= (w_state_next == RUN);
      r_done      <= (w_state_next == DONE);
      r_match     <= w_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= LEN_W'(PAT_W);
      r_overlap <= 1'b1;
      r_window  <= '0;
    end else if (w_cfg_load) begin
      r_pattern <= cfg_pattern;
      r_len     <= cfg_len;
      r_overlap <= cfg_overlap;
      r_window  <= cfg_window;
    end
  end

  // Window and match counters; the match count holds between scans.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
      r_count     <= '0;
    end else begin
      if (w_start) begin
        r_remaining <= w_eff_window;
      end else if (w_shift) begin
        r_remaining <= r_remaining - WIN_W'(1);
      end

      if (w_start) begin
        r_count <= '0;
      end else if (w_hit && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign busy        = r_busy;
  assign match       = r_match;
  assign done        = r_done;
  assign match_count = r_count;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scan table plus randomized scans checked
// cycle by cycle against a bit-string match model (8-bit and 2-bit counters).
module tb_seq_det_ctrl;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned WIN_W = 16;
  localparam int unsigned LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [WIN_W-1:0] cfg_window;
  logic             start;
  logic             abort;
  logic             din;
  logic             din_valid;

  logic       cfg_ready_a, busy_a, match_a, done_a;
  logic [7:0] cnt_a;
  logic       cfg_ready_b, busy_b, match_b, done_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;
  int g_total = 0;

  typedef struct {
    string       name;
    logic [3:0]  pat;
    logic [2:0]  len;
    bit          ovl;
    int          win;
    logic [63:0] bits;
    int          vmode;
    int          cfg_mode;
    int          stop_at;
    int          stop_kind;
    int          exp_cnt;
    logic [63:0] exp_hits;
  } vec_t;

  vec_t tbl[12];

  seq_det_ctrl #(.PAT_W(4), .CNT_W(8), .WIN_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_window(cfg_window), .start(start), .abort(abort), .din(din),
    .din_valid(din_valid), .busy(busy_a), .match(match_a), .done(done_a),
    .match_count(cnt_a)
  );

  seq_det_ctrl #(.PAT_W(4), .CNT_W(2), .WIN_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_window(cfg_window), .start(start), .abort(abort), .din(din),
    .din_valid(din_valid), .busy(busy_b), .match(match_b), .done(done_b),
    .match_count(cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  function automatic int sat(input int t, input int m);
    return (t > m) ? m : t;
  endfunction

  task automatic check_outs(input string tag, input bit e_busy, input bit e_match,
                            input bit e_done, input bit e_rdy, input int total);
    chk({tag, " busy"},      32'(busy_a),      32'(e_busy));
    chk({tag, " match"},     32'(match_a),     32'(e_match));
    chk({tag, " done"},      32'(done_a),      32'(e_done));
    chk({tag, " cfg_ready"}, 32'(cfg_ready_a), 32'(e_rdy));
    chk({tag, " count"},     32'(cnt_a),       32'(sat(total, 255)));
    chk({tag, " match_b"},   32'(match_b),     32'(e_match));
    chk({tag, " done_b"},    32'(done_b),      32'(e_done));
    chk({tag, " count_b"},   32'(cnt_b),       32'(sat(total, 3)));
  endtask

  task automatic idle_inputs;
    cfg_valid = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic junk_cfg;
    cfg_pattern = 4'($urandom);
    cfg_len     = 3'($urandom);
    cfg_overlap = 1'($urandom);
    cfg_window  = 16'($urandom);
  endtask

  // Match k (1-based bit count) when the last L received bits spell the pattern,
  // pattern MSB first; non-overlapping mode also needs L bits since the last match.
  function automatic logic [63:0] model_hits(input logic [63:0] bits, input logic [3:0] pat,
                                             input int len, input bit ovl, input int win);
    int l;
    int last_end;
    bit ok;
    logic [63:0] r;
    l = (len == 0 || len > 4) ? 4 : len;
    last_end = 0;
    r = '0;
    for (int k = 1; k <= win; k++) begin
      if (k - (ovl ? 0 : last_end) >= l) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          if (bits[k-1-j] != pat[j]) ok = 1'b0;
        end
        if (ok) begin
          r[k-1] = 1'b1;
          last_end = k;
        end
      end
    end
    return r;
  endfunction

  function automatic vec_t mk(input string name, input logic [3:0] pat, input logic [2:0] len,
                              input bit ovl, input int win, input logic [63:0] bits,
                              input int vmode, input int cfg_mode, input int stop_at,
                              input int stop_kind, input int exp_cnt, input logic [63:0] hits);
    vec_t v;
    v.name = name; v.pat = pat; v.len = len; v.ovl = ovl; v.win = win; v.bits = bits;
    v.vmode = vmode; v.cfg_mode = cfg_mode; v.stop_at = stop_at; v.stop_kind = stop_kind;
    v.exp_cnt = exp_cnt; v.exp_hits = hits;
    return v;
  endfunction

  task automatic run_scan(input vec_t v);
    int  k;
    int  guard;
    bit  dv;
    bit  m;
    k = 0;
    guard = 0;
    if (v.cfg_mode == 1) begin
      cfg_valid = 1'b1; start = 1'b0; abort = 1'($urandom);
      cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ovl; cfg_window = 16'(v.win);
      tick;
      idle_inputs;
      check_outs({v.name, " cfg"}, 1'b0, 1'b0, 1'b0, 1'b1, g_total);
    end
    if (v.cfg_mode == 0) begin
      cfg_valid = 1'b1;
      cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ovl; cfg_window = 16'(v.win);
    end else begin
      cfg_valid = 1'b0;
      junk_cfg;
    end
    start = 1'b1; abort = 1'($urandom); din_valid = 1'($urandom); din = 1'($urandom);
    tick;
    idle_inputs;
    g_total = 0;
    if (v.win == 0) begin
      check_outs({v.name, " start"}, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    end else begin
      check_outs({v.name, " start"}, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      while (k < v.win && guard < 2000) begin
        guard++;
        start = 1'($urandom); cfg_valid = 1'($urandom); junk_cfg;
        if (k == v.stop_at) begin
          din_valid = 1'b1; din = v.bits[k];
          if (v.stop_kind == 0) begin
            abort = 1'b1;
            tick;
            idle_inputs;
            check_outs({v.name, " abort"}, 1'b0, 1'b0, 1'b0, 1'b1, g_total);
          end else begin
            rst = 1'b1;
            tick;
            rst = 1'b0;
            idle_inputs;
            g_total = 0;
            check_outs({v.name, " rst"}, 1'b0, 1'b0, 1'b0, 1'b1, 0);
          end
          chk({v.name, " final"}, 32'(cnt_a), 32'(sat(v.exp_cnt, 255)));
          return;
        end
        case (v.vmode)
          0:       dv = 1'b1;
          1:       dv = (guard % 2) == 0;
          default: dv = ($urandom_range(0, 3) != 0);
        endcase
        din_valid = dv;
        din = dv ? v.bits[k] : 1'($urandom);
        tick;
        if (dv) begin
          k++;
          m = v.exp_hits[k-1];
          if (m) g_total++;
          check_outs(v.name, k != v.win, m, k == v.win, 1'b0, g_total);
        end else begin
          check_outs({v.name, " stall"}, 1'b1, 1'b0, 1'b0, 1'b0, g_total);
        end
      end
      if (k != v.win) begin
        chk({v.name, " timeout bits"}, 32'(k), 32'(v.win));
        rst = 1'b1; tick; rst = 1'b0; idle_inputs; g_total = 0;
        return;
      end
    end
    // DONE cycle: new requests and abort must be ignored
    start = 1'b1; cfg_valid = 1'($urandom); abort = 1'($urandom); junk_cfg;
    tick;
    idle_inputs;
    check_outs({v.name, " idle"}, 1'b0, 1'b0, 1'b0, 1'b1, g_total);
    chk({v.name, " final"}, 32'(cnt_a), 32'(sat(v.exp_cnt, 255)));
    chk({v.name, " final_b"}, 32'(cnt_b), 32'(sat(v.exp_cnt, 3)));
  endtask

  initial begin
    vec_t rv;
    int   cnt;
    int   lim;

    tbl[0]  = mk("T1_ovl",      4'b1010, 3'd4, 1'b1, 8, 64'hD5, 0, 0, -1, 0, 2, 64'h28);
    tbl[1]  = mk("T2_novl",     4'b1010, 3'd4, 1'b0, 8, 64'hD5, 0, 0, -1, 0, 1, 64'h08);
    tbl[2]  = mk("T3_win0",     4'b1010, 3'd4, 1'b1, 0, 64'h00, 0, 0, -1, 0, 0, 64'h00);
    tbl[3]  = mk("T4_gaps",     4'b1010, 3'd4, 1'b1, 8, 64'hD5, 1, 0, -1, 0, 2, 64'h28);
    tbl[4]  = mk("T5_abort5",   4'b1010, 3'd4, 1'b1, 8, 64'hD5, 0, 0,  5, 0, 1, 64'h28);
    tbl[5]  = mk("abort_beats", 4'b1010, 3'd4, 1'b1, 8, 64'hD5, 0, 0,  3, 0, 0, 64'h28);
    tbl[6]  = mk("T5_rst",      4'b1010, 3'd4, 1'b1, 8, 64'hD5, 0, 0,  3, 1, 0, 64'h28);
    tbl[7]  = mk("rst_cfg",     4'b0000, 3'd4, 1'b1, 0, 64'h00, 0, 2, -1, 0, 0, 64'h00);
    tbl[8]  = mk("T6_sat",      4'b0011, 3'd2, 1'b1, 8, 64'hFF, 0, 0, -1, 0, 7, 64'hFE);
    tbl[9]  = mk("len0",        4'b1111, 3'd0, 1'b1, 8, 64'hFF, 0, 0, -1, 0, 5, 64'hF8);
    tbl[10] = mk("len7_sep",    4'b1010, 3'd7, 1'b1, 8, 64'hD5, 0, 1, -1, 0, 2, 64'h28);
    tbl[11] = mk("novl_len2",   4'b0011, 3'd2, 1'b0, 8, 64'hFF, 0, 0, -1, 0, 4, 64'hAA);

    rst = 1'b1;
    idle_inputs;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_window = '0;
    tick;
    tick;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    rst = 1'b0;

    // abort and stray data in IDLE change nothing
    abort = 1'b1; din_valid = 1'b1; din = 1'b1;
    tick;
    tick;
    idle_inputs;
    check_outs("idle_abort", 1'b0, 1'b0, 1'b0, 1'b1, 0);

    for (int i = 0; i < 12; i++) begin
      run_scan(tbl[i]);
    end

    for (int n = 0; n < 40; n++) begin
      rv.name     = $sformatf("rand%0d", n);
      rv.pat      = 4'($urandom);
      rv.len      = 3'($urandom_range(0, 7));
      rv.ovl      = 1'($urandom);
      rv.win      = $urandom_range(0, 40);
      rv.bits     = {$urandom, $urandom};
      rv.vmode    = 2;
      rv.cfg_mode = $urandom_range(0, 1);
      rv.stop_at  = (rv.win > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, rv.win - 1) : -1;
      rv.stop_kind = 0;
      rv.exp_hits = model_hits(rv.bits, rv.pat, int'(rv.len), rv.ovl, rv.win);
      lim = (rv.stop_at >= 0) ? rv.stop_at : rv.win;
      cnt = 0;
      for (int k = 0; k < lim; k++) begin
        if (rv.exp_hits[k]) cnt++;
      end
      rv.exp_cnt = cnt;
      run_scan(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
